// File: rtl/mem_arb_pkg.sv
// Shared types for the L1 lower-memory arbiter: FSM encoding, requester
// indices and the registered request payload driven onto the memory port.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

  // Payload widths; the arbiter's ADDR_WIDTH/DATA_WIDTH default to these.
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. last_grant_i names the requester that owned the
// port most recently (0 = I-cache, 1 = D-cache); on a tie the other one wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot pick; a tie goes to whoever did not win last time.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one lower-memory port between the L1 I-cache (requester 0) and the
// L1 D-cache (requester 1). One outstanding transaction at a time, round-robin
// fairness, and a watchdog that abandons a transaction memory never answers.
// rstn asserts asynchronously; its release is expected to be synchronised to
// clk upstream.
module l1_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_response_data,
  input  logic                  mem_ready,
  output logic [1:0]            grant,
  output logic [1:0]            arb_state,
  output logic                  timeout_flag,
  input  logic                  timeout_clear
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t       state_q;
  logic [1:0]       grant_q;
  logic             last_grant_q;   // 0 = I-cache owned last, 1 = D-cache
  logic             mem_req_q;
  mem_req_t         payload_q;
  logic [CNT_W-1:0] wdog_q;
  logic             timeout_q;
  logic             timeout_d;

  logic [1:0]       pick;
  mem_req_t         i_payload;
  mem_req_t         d_payload;
  logic             busy_ready;
  logic             wdog_fire;

  assign i_payload = '{addr: i_addr, we: i_we, wdata: i_wdata};
  assign d_payload = '{addr: d_addr, we: d_we, wdata: d_wdata};

  rr_arbiter2 u_rr (
    .req_i        ({d_req, i_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (pick)
  );

  // mem_ready only counts while a transaction is outstanding; it beats the
  // watchdog if both land in the same cycle.
  assign busy_ready = (state_q == BUSY) && mem_ready;
  assign wdog_fire  = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) && !mem_ready
                      && (wdog_q == WDOG_LAST);

  // Arbitration FSM: grant in IDLE, hold the port in BUSY, one idle TURN cycle
  // so the finishing cache sees mem_request low before anyone is re-granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      payload_q    <= '0;
      wdog_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pick) begin
            grant_q      <= pick;
            last_grant_q <= pick[REQ_DCACHE];
            payload_q    <= pick[REQ_DCACHE] ? d_payload : i_payload;
            mem_req_q    <= 1'b1;
            wdog_q       <= '0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          wdog_q <= wdog_q + CNT_W'(1);
          if (mem_ready || wdog_fire) begin
            mem_req_q <= 1'b0;
            grant_q   <= 2'b00;
            state_q   <= TURN;
          end
        end
        TURN:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flag: a new timeout overrides a simultaneous clear.
  always_comb begin
    timeout_d = timeout_q;
    if (timeout_clear) timeout_d = 1'b0;
    if (wdog_fire)     timeout_d = 1'b1;
  end

  // Register the watchdog error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  // Completion is only reported to an owner that is still asking for it.
  assign i_ready = busy_ready && grant_q[REQ_ICACHE] && i_req;
  assign d_ready = busy_ready && grant_q[REQ_DCACHE] && d_req;
  assign i_rdata = i_ready ? mem_response_data : '0;
  assign d_rdata = d_ready ? mem_response_data : '0;

  assign mem_request      = mem_req_q;
  assign mem_address      = payload_q.addr;
  assign mem_write_enable = payload_q.we;
  assign mem_write_data   = payload_q.wdata;
  assign grant            = grant_q;
  assign arb_state        = state_q;
  assign timeout_flag     = timeout_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios plus a randomised run checked
// against a round-robin transaction model.
module tb_l1_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req, i_we, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_request, mem_write_enable, mem_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_response_data;
  logic [1:0]    grant, arb_state;
  logic          timeout_flag, timeout_clear;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_request(mem_request), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_response_data(mem_response_data), .mem_ready(mem_ready),
    .grant(grant), .arb_state(arb_state),
    .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; timeout_clear = 1'b0;
    i_we = 1'b0; d_we = 1'b0; i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_response_data = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();
  endtask

  // Memory side: called in the first BUSY cycle, waits lat cycles, pulses
  // mem_ready for one cycle and records what each cache saw.
  task automatic respond(input int lat, input logic [DW-1:0] data,
                         output logic ri, output logic rd,
                         output logic [DW-1:0] di, output logic [DW-1:0] dd);
    for (int k = 0; k < lat; k++) step();
    mem_ready = 1'b1; mem_response_data = data;
    #1;
    ri = i_ready; rd = d_ready; di = i_rdata; dd = d_rdata;
    step();
    mem_ready = 1'b0; mem_response_data = $urandom;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; timeout_clear = 1'b0;
    i_addr = 32'hFFFF_FFFF; d_addr = 32'hAAAA_AAAA; i_we = 1'b1; d_we = 1'b1;
    i_wdata = 32'h5555_5555; d_wdata = 32'h7777_7777; mem_response_data = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem_request !== 1'b0) $display("FAIL rst_mem_request got %0h want 0", mem_request); else passed++;
    total++; if (mem_address !== '0) $display("FAIL rst_mem_address got %0h want 0", mem_address); else passed++;
    total++; if (mem_write_enable !== 1'b0) $display("FAIL rst_mem_we got %0h want 0", mem_write_enable); else passed++;
    total++; if (mem_write_data !== '0) $display("FAIL rst_mem_wdata got %0h want 0", mem_write_data); else passed++;
    total++; if (grant !== 2'b00) $display("FAIL rst_grant got %0h want 0", grant); else passed++;
    total++; if (arb_state !== 2'd0) $display("FAIL rst_state got %0d want 0", arb_state); else passed++;
    total++; if (timeout_flag !== 1'b0) $display("FAIL rst_timeout_flag got %0h want 0", timeout_flag); else passed++;
    total++; if ({i_ready, d_ready} !== 2'b00) $display("FAIL rst_ready got %0h want 0", {i_ready, d_ready}); else passed++;
    total++; if ({i_rdata, d_rdata} !== '0) $display("FAIL rst_rdata got %0h want 0", {i_rdata, d_rdata}); else passed++;
    do_reset();
    total++; if (arb_state !== 2'd0) $display("FAIL rst_release_state got %0d want 0", arb_state); else passed++;
  endtask

  task automatic test_single_read();
    logic ri, rd; logic [DW-1:0] di, dd;
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0040; i_we = 1'b0;
    #1;
    total++; if (mem_request !== 1'b0) $display("FAIL rd_latency_early got %0h want 0", mem_request); else passed++;
    step();
    total++; if (mem_request !== 1'b1) $display("FAIL rd_mem_request got %0h want 1", mem_request); else passed++;
    total++; if (mem_address !== 32'h40) $display("FAIL rd_mem_address got %0h want 40", mem_address); else passed++;
    total++; if (grant !== 2'b01) $display("FAIL rd_grant got %0h want 1", grant); else passed++;
    total++; if (arb_state !== 2'd1) $display("FAIL rd_state_busy got %0d want 1", arb_state); else passed++;
    respond(3, 32'hDEAD_BEEF, ri, rd, di, dd);
    total++; if (ri !== 1'b1) $display("FAIL rd_i_ready got %0h want 1", ri); else passed++;
    total++; if (di !== 32'hDEAD_BEEF) $display("FAIL rd_i_rdata got %0h want deadbeef", di); else passed++;
    total++; if (rd !== 1'b0 || dd !== '0) $display("FAIL rd_d_side got %0h/%0h want 0/0", rd, dd); else passed++;
    i_req = 1'b0;
    total++; if (arb_state !== 2'd2 || mem_request !== 1'b0) $display("FAIL rd_turn got state %0d req %0h want 2/0", arb_state, mem_request); else passed++;
    step();
    total++; if (arb_state !== 2'd0) $display("FAIL rd_idle got %0d want 0", arb_state); else passed++;
  endtask

  task automatic test_back_to_back();
    logic ri, rd; logic [DW-1:0] di, dd;
    logic [1:0] want;
    do_reset();
    i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_addr = 32'h2000;
    step();
    for (int n = 0; n < 4; n++) begin
      want = (n % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (grant !== want) $display("FAIL b2b_grant%0d got %0h want %0h", n, grant, want); else passed++;
      total++; if (mem_request !== 1'b1 || mem_address !== (want[0] ? 32'h1000 : 32'h2000))
        $display("FAIL b2b_addr%0d got %0h/%0h want 1/%0h", n, mem_request, mem_address, want[0] ? 32'h1000 : 32'h2000); else passed++;
      respond(2, 32'h100 + DW'(n), ri, rd, di, dd);
      total++; if ({rd, ri} !== want || (want[0] ? di : dd) !== 32'h100 + DW'(n))
        $display("FAIL b2b_ready%0d got %0h data %0h want %0h data %0h", n, {rd, ri}, want[0] ? di : dd, want, 32'h100 + n); else passed++;
      if (n < 3) begin
        total++; if (arb_state !== 2'd2) $display("FAIL b2b_turn%0d got %0d want 2", n, arb_state); else passed++;
        step();
        total++; if (arb_state !== 2'd0 || mem_request !== 1'b0) $display("FAIL b2b_idle%0d got %0d/%0h want 0/0", n, arb_state, mem_request); else passed++;
        step();
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_dwrite();
    logic ri, rd; logic [DW-1:0] di, dd;
    do_reset();
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'h1234_5678;
    step();
    d_addr = 32'hBAD0; d_wdata = 32'hBAD1;
    for (int k = 0; k < 4; k++) begin
      total++; if (grant !== 2'b10 || mem_address !== 32'h100 || mem_write_enable !== 1'b1 || mem_write_data !== 32'h1234_5678)
        $display("FAIL wr_hold%0d got g%0h a%0h we%0h d%0h want g2 a100 we1 d12345678", k, grant, mem_address, mem_write_enable, mem_write_data); else passed++;
      step();
    end
    respond(0, 32'h0, ri, rd, di, dd);
    total++; if (rd !== 1'b1) $display("FAIL wr_d_ready got %0h want 1", rd); else passed++;
    total++; if (ri !== 1'b0 || di !== '0) $display("FAIL wr_i_side got %0h/%0h want 0/0", ri, di); else passed++;
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    i_req = 1'b1; i_addr = 32'h80;
    step();
    cnt = 0;
    while (mem_request === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    total++; if (cnt !== TO) $display("FAIL to_busy_cycles got %0d want %0d", cnt, TO); else passed++;
    total++; if (timeout_flag !== 1'b1) $display("FAIL to_flag_set got %0h want 1", timeout_flag); else passed++;
    total++; if (arb_state !== 2'd2 || grant !== 2'b00) $display("FAIL to_turn got %0d/%0h want 2/0", arb_state, grant); else passed++;
    timeout_clear = 1'b1;
    step();
    timeout_clear = 1'b0;
    total++; if (timeout_flag !== 1'b0) $display("FAIL to_flag_clear got %0h want 0", timeout_flag); else passed++;
    step();
    total++; if (mem_request !== 1'b1 || grant !== 2'b01) $display("FAIL to_rearb got %0h/%0h want 1/1", mem_request, grant); else passed++;
    repeat (7) step();
    total++; if (mem_request !== 1'b1) $display("FAIL to_last_busy got %0h want 1", mem_request); else passed++;
    timeout_clear = 1'b1;
    step();
    timeout_clear = 1'b0;
    total++; if (timeout_flag !== 1'b1 || mem_request !== 1'b0) $display("FAIL to_set_wins got %0h/%0h want 1/0", timeout_flag, mem_request); else passed++;
    mem_ready = 1'b1; mem_response_data = 32'h1111_2222;
    #1;
    total++; if (i_ready !== 1'b0 || i_rdata !== '0) $display("FAIL to_ready_in_turn got %0h/%0h want 0/0", i_ready, i_rdata); else passed++;
    mem_ready = 1'b0; i_req = 1'b0; timeout_clear = 1'b1;
    step();
    timeout_clear = 1'b0;
    total++; if (timeout_flag !== 1'b0) $display("FAIL to_flag_clear2 got %0h want 0", timeout_flag); else passed++;
    step();
  endtask

  task automatic test_reset_busy();
    logic ri, rd; logic [DW-1:0] di, dd;
    do_reset();
    i_req = 1'b1; i_addr = 32'h44;
    step();
    total++; if (mem_request !== 1'b1) $display("FAIL rb_pre_busy got %0h want 1", mem_request); else passed++;
    mem_ready = 1'b1; mem_response_data = 32'h9999_8888;
    rstn = 1'b0;
    #1;
    total++; if (mem_request !== 1'b0 || mem_address !== '0 || grant !== 2'b00 || arb_state !== 2'd0)
      $display("FAIL rb_async got req%0h a%0h g%0h s%0d want all 0", mem_request, mem_address, grant, arb_state); else passed++;
    total++; if (i_ready !== 1'b0 || i_rdata !== '0) $display("FAIL rb_no_ready got %0h/%0h want 0/0", i_ready, i_rdata); else passed++;
    mem_ready = 1'b0;
    step();
    rstn = 1'b1;
    step();
    total++; if (mem_request !== 1'b1 || grant !== 2'b01 || mem_address !== 32'h44)
      $display("FAIL rb_after got req%0h g%0h a%0h want 1/1/44", mem_request, grant, mem_address); else passed++;
    respond(1, 32'h0BAD_CAFE, ri, rd, di, dd);
    total++; if (ri !== 1'b1 || di !== 32'h0BAD_CAFE) $display("FAIL rb_served got %0h/%0h want 1/badcafe", ri, di); else passed++;
    i_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_abort();
    logic ri, rd; logic [DW-1:0] di, dd;
    do_reset();
    i_req = 1'b1; i_addr = 32'h200;
    step();
    step();
    i_req = 1'b0;
    respond(1, 32'h5A5A_5A5A, ri, rd, di, dd);
    total++; if (ri !== 1'b0 || di !== '0 || rd !== 1'b0) $display("FAIL ab_no_ready got %0h/%0h/%0h want 0/0/0", ri, di, rd); else passed++;
    total++; if (arb_state !== 2'd2) $display("FAIL ab_turn got %0d want 2", arb_state); else passed++;
    step();
    total++; if (arb_state !== 2'd0) $display("FAIL ab_idle got %0d want 0", arb_state); else passed++;
    i_req = 1'b1; mem_ready = 1'b1; mem_response_data = 32'h7E57_7E57;
    #1;
    total++; if (i_ready !== 1'b0 || i_rdata !== '0) $display("FAIL ab_ready_in_idle got %0h/%0h want 0/0", i_ready, i_rdata); else passed++;
    i_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  // Random traffic against a transaction-level model: pending requests per
  // cache, and a round-robin choice when both are pending.
  task automatic test_random();
    logic          pend[2];
    logic [AW-1:0] pa[2];
    logic          pw[2];
    logic [DW-1:0] pd[2];
    logic          rdy[2];
    logic [DW-1:0] rdt[2];
    logic [DW-1:0] data;
    logic [1:0]    want;
    int            win, last;
    do_reset();
    last = 1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && $urandom_range(0, 2) != 0) begin
          pend[s] = 1'b1; pa[s] = $urandom; pw[s] = 1'($urandom_range(0, 1)); pd[s] = $urandom;
        end
      end
      i_req = pend[0]; i_addr = pa[0]; i_we = pw[0]; i_wdata = pd[0];
      d_req = pend[1]; d_addr = pa[1]; d_we = pw[1]; d_wdata = pd[1];
      step();
      if (!pend[0] && !pend[1]) begin
        total++; if (arb_state !== 2'd0 || mem_request !== 1'b0) $display("FAIL rnd_idle%0d got %0d/%0h want 0/0", r, arb_state, mem_request); else passed++;
        continue;
      end
      if (pend[0] && pend[1]) win = (last == 1) ? 0 : 1;
      else                    win = pend[1] ? 1 : 0;
      want = (win == 0) ? 2'b01 : 2'b10;
      total++; if (grant !== want || mem_request !== 1'b1) $display("FAIL rnd_grant%0d got %0h/%0h want %0h/1", r, grant, mem_request, want); else passed++;
      total++; if (mem_address !== pa[win] || mem_write_enable !== pw[win] || mem_write_data !== pd[win])
        $display("FAIL rnd_payload%0d got %0h/%0h/%0h want %0h/%0h/%0h", r, mem_address, mem_write_enable, mem_write_data, pa[win], pw[win], pd[win]); else passed++;
      data = $urandom;
      respond(int'($urandom_range(0, 6)), data, rdy[0], rdy[1], rdt[0], rdt[1]);
      total++; if (rdy[win] !== 1'b1 || rdt[win] !== data) $display("FAIL rnd_ready%0d got %0h/%0h want 1/%0h", r, rdy[win], rdt[win], data); else passed++;
      total++; if (rdy[1-win] !== 1'b0 || rdt[1-win] !== '0) $display("FAIL rnd_other%0d got %0h/%0h want 0/0", r, rdy[1-win], rdt[1-win]); else passed++;
      pend[win] = 1'b0; last = win;
      if (win == 0) i_req = 1'b0; else d_req = 1'b0;
      total++; if (arb_state !== 2'd2) $display("FAIL rnd_turn%0d got %0d want 2", r, arb_state); else passed++;
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_dwrite();
    test_timeout();
    test_reset_busy();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
